mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter that shares the single line-wide external memory port between the L1 instruction cache and the L1 data cache. It sits between both caches' memory-side interfaces (strobe/address/ready/line data) and the memory controller. One transaction is in flight at a time. Ties are resolved round-robin, and every transaction is completed before the port is re-arbitrated.

## Interface
- ADDR_WIDTH, 32, address width
- LINE_SIZE, 256, line width in bits; one transfer moves one line
- clk_i  in  1  system clock
- rst_ni  in  1  reset, asynchronous, active-low
- i_strobe_i  in  1  I-cache line-read request, level, held until i_ready_o
- i_addr_i  in  ADDR_WIDTH  I-cache line address, stable while i_strobe_i is high
- i_ready_o  out  1  one-cycle completion pulse to I-cache
- i_data_o  out  LINE_SIZE  line data to I-cache, valid when i_ready_o is high
- d_strobe_i  in  1  D-cache request, level, held until d_ready_o
- d_rw_i  in  1  D-cache direction: 0 = line read, 1 = line write-back
- d_addr_i  in  ADDR_WIDTH  D-cache line address
- d_wdata_i  in  LINE_SIZE  D-cache write-back line
- d_ready_o  out  1  one-cycle completion pulse to D-cache
- d_data_o  out  LINE_SIZE  line data to D-cache, valid on d_ready_o when d_rw_i = 0
- m_strobe_o  out  1  memory request, registered
- m_rw_o  out  1  memory direction, registered
- m_addr_o  out  ADDR_WIDTH  memory address, registered
- m_wdata_o  out  LINE_SIZE  memory write line, registered
- m_ready_i  in  1  memory completion pulse
- m_data_i  in  LINE_SIZE  memory read line, valid with m_ready_i
- i_cnt_o  out  32  completed I-cache transactions
- d_cnt_o  out  32  completed D-cache transactions

## Operation
- The FSM has three states: IDLE, SERVE, RECOVER.
- **IDLE**
  - Samples i_strobe_i and d_strobe_i.
  - If only one is high, that requester wins.
  - If both are high, the requester not recorded in last_gnt wins. last_gnt resets to D, so the I-cache wins the first tie.
  - On a win: latch the winner's address, direction and wdata into the m_* registers, set m_strobe_o = 1, record the owner, and go to SERVE.
  - I-cache transactions always use m_rw_o = 0 and m_wdata_o = 0.
- **SERVE**
  - m_* outputs are held constant.
  - Requester strobes are ignored. A requester dropping its strobe does not abort the transaction.
  - When m_ready_i is high:
    - Drive the owner's ready_o high combinationally in the same cycle.
    - Clear m_strobe_o, m_addr_o, m_wdata_o and m_rw_o to 0 at the next edge.
    - Set last_gnt = owner and increment the owner's counter.
    - Go to RECOVER.
- **RECOVER**
  - Lasts exactly one cycle, then returns to IDLE.
  - Strobes are ignored in this state. Cache strobes are registered, so they are still high in the cycle after ready.
- i_data_o and d_data_o are both wired to m_data_i. Only the ready pulses are gated by ownership.
- A non-owner's ready_o is never asserted.
- m_ready_i in IDLE or RECOVER is ignored: no ready_o pulse, no state change, no counter change.
- m_addr_o, m_wdata_o, m_rw_o and m_strobe_o are 0 whenever the state is not SERVE.
- Counters are 32-bit and wrap from 0xFFFFFFFF to 0 with no flag.
- Fairness: a pending requester waits at most one complete foreign transaction plus 2 cycles.

## Timing
- Reset (rst_ni low, asynchronous):
  - All outputs are 0.
  - State = IDLE, last_gnt = D, both counters = 0.
  - An in-flight transaction is abandoned with no ready pulse.
  - Release is synchronous to the next clk_i edge.
- Request to memory: strobe first seen high in IDLE at cycle t gives m_strobe_o high from cycle t+1.
- Return path: ready_o is asserted in the same cycle as m_ready_i. The arbiter adds no latency.
- Completion: m_ready_i at cycle r gives m_strobe_o low at r+1 (RECOVER) and IDLE at r+2. The earliest next m_strobe_o is at r+3.
- Simultaneous first assertion of both strobes in IDLE is resolved by last_gnt. Requests are never merged.
- m_ready_i arriving in the same cycle as the IDLE-to-SERVE transition cannot occur, because m_strobe_o is still low in that cycle. Any such pulse is ignored.

## Test plan
- **Single I-cache read:**
  - Stimulus: i_strobe_i rises at cycle 2 with i_addr_i = 0x8000_0040; memory returns m_ready_i at cycle 6 with data 0xA5…A5.
  - Required: m_strobe_o = 1 in cycles 3–6; m_addr_o = 0x8000_0040; m_rw_o = 0; i_ready_o = 1 only in cycle 6 with i_data_o = 0xA5…A5; d_ready_o stays 0; i_cnt_o = 1.
- **Simultaneous requests after reset:**
  - Stimulus: both strobes rise at the same cycle.
  - Required: I-cache is served first. D-cache m_strobe_o rises exactly 3 cycles after the I-cache ready. Then re-assert both strobes: D-cache is not served first; I-cache wins only if the D-cache was served last.
- **D-cache write-back:**
  - Stimulus: d_rw_i = 1, d_addr_i = 0x8000_1000, d_wdata_i = 0x0123…EF.
  - Required: m_rw_o = 1, m_wdata_o = 0x0123…EF; one d_ready_o pulse on m_ready_i; m_wdata_o returns to 0 in RECOVER.
- **Stale strobe and spurious ready:**
  - Stimulus: the requester's strobe stays high one cycle after its ready pulse; separately, pulse m_ready_i while in IDLE.
  - Required: no second transaction is issued; no ready_o pulse; counters unchanged.
- **Reset mid-SERVE:**
  - Stimulus: drive rst_ni low between clock edges while in SERVE.
  - Required: m_strobe_o, m_addr_o and both counters drop to 0 immediately, before the next edge. After release, a tie is won by the I-cache.
- **Counter wrap:**
  - Stimulus: force i_cnt_o to 0xFFFFFFFF, then complete one I-cache transaction.
  - Required: i_cnt_o = 0 and d_cnt_o is unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between the L1 I-cache
// and L1 D-cache; one transaction in flight, each completed before re-arbitration.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_SIZE  = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    // I-cache side
    input  logic                  i_strobe_i,
    input  logic [ADDR_WIDTH-1:0] i_addr_i,
    output logic                  i_ready_o,
    output logic [LINE_SIZE-1:0]  i_data_o,
    // D-cache side
    input  logic                  d_strobe_i,
    input  logic                  d_rw_i,
    input  logic [ADDR_WIDTH-1:0] d_addr_i,
    input  logic [LINE_SIZE-1:0]  d_wdata_i,
    output logic                  d_ready_o,
    output logic [LINE_SIZE-1:0]  d_data_o,
    // Memory side
    output logic                  m_strobe_o,
    output logic                  m_rw_o,
    output logic [ADDR_WIDTH-1:0] m_addr_o,
    output logic [LINE_SIZE-1:0]  m_wdata_o,
    input  logic                  m_ready_i,
    input  logic [LINE_SIZE-1:0]  m_data_i,
    // Completion counters
    output logic [31:0]           i_cnt_o,
    output logic [31:0]           d_cnt_o
);

    // Handshake: cache strobes are levels held until their one-cycle ready
    // pulse; m_strobe_o is held through SERVE until the m_ready_i pulse, and
    // m_ready_i outside SERVE is ignored.

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE   = 2'd1,
        RECOVER = 2'd2
    } state_t;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    state_t                state_q,    state_d;
    logic                  owner_q,    owner_d;
    logic                  last_gnt_q, last_gnt_d;
    logic                  m_strobe_q, m_strobe_d;
    logic                  m_rw_q,     m_rw_d;
    logic [ADDR_WIDTH-1:0] m_addr_q,   m_addr_d;
    logic [LINE_SIZE-1:0]  m_wdata_q,  m_wdata_d;
    logic [31:0]           i_cnt_q,    i_cnt_d;
    logic [31:0]           d_cnt_q,    d_cnt_d;

    logic                  pick_d;
    logic                  done;

    // D wins if it is the only requester, or on a tie when I was granted last.
    assign pick_d = d_strobe_i && (!i_strobe_i || (last_gnt_q == OWN_I));
    assign done   = (state_q == SERVE) && m_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            owner_q    <= OWN_I;
            last_gnt_q <= OWN_D;
            m_strobe_q <= 1'b0;
            m_rw_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            i_cnt_q    <= '0;
            d_cnt_q    <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_gnt_q <= last_gnt_d;
            m_strobe_q <= m_strobe_d;
            m_rw_q     <= m_rw_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            i_cnt_q    <= i_cnt_d;
            d_cnt_q    <= d_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_gnt_d = last_gnt_q;
        m_strobe_d = m_strobe_q;
        m_rw_d     = m_rw_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        i_cnt_d    = i_cnt_q;
        d_cnt_d    = d_cnt_q;

        case (state_q)
            IDLE: begin
                if (i_strobe_i || d_strobe_i) begin
                    state_d    = SERVE;
                    m_strobe_d = 1'b1;
                    owner_d    = pick_d ? OWN_D : OWN_I;
                    if (pick_d) begin
                        m_rw_d    = d_rw_i;
                        m_addr_d  = d_addr_i;
                        m_wdata_d = d_wdata_i;
                    end else begin
                        m_rw_d    = 1'b0;
                        m_addr_d  = i_addr_i;
                        m_wdata_d = '0;
                    end
                end
            end

            SERVE: begin
                if (m_ready_i) begin
                    state_d    = RECOVER;
                    m_strobe_d = 1'b0;
                    m_rw_d     = 1'b0;
                    m_addr_d   = '0;
                    m_wdata_d  = '0;
                    last_gnt_d = owner_q;
                    if (owner_q == OWN_I) begin
                        i_cnt_d = i_cnt_q + 32'd1;
                    end else begin
                        d_cnt_d = d_cnt_q + 32'd1;
                    end
                end
            end

            // Strobes seen here are stale copies of the request just finished.
            RECOVER: begin
                state_d = IDLE;
            end

            default: begin
                state_d    = IDLE;
                m_strobe_d = 1'b0;
                m_rw_d     = 1'b0;
                m_addr_d   = '0;
                m_wdata_d  = '0;
            end
        endcase
    end

    assign i_ready_o  = done && (owner_q == OWN_I);
    assign d_ready_o  = done && (owner_q == OWN_D);
    assign i_data_o   = m_data_i;
    assign d_data_o   = m_data_i;

    assign m_strobe_o = m_strobe_q;
    assign m_rw_o     = m_rw_q;
    assign m_addr_o   = m_addr_q;
    assign m_wdata_o  = m_wdata_q;

    assign i_cnt_o    = i_cnt_q;
    assign d_cnt_o    = d_cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single reads, ties, write-back, stale and
// spurious handshakes, asynchronous reset mid-transaction and counter wrap.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int LS = 256;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          i_strobe_i = 1'b0;
    logic [AW-1:0] i_addr_i = '0;
    logic          i_ready_o;
    logic [LS-1:0] i_data_o;
    logic          d_strobe_i = 1'b0;
    logic          d_rw_i = 1'b0;
    logic [AW-1:0] d_addr_i = '0;
    logic [LS-1:0] d_wdata_i = '0;
    logic          d_ready_o;
    logic [LS-1:0] d_data_o;
    logic          m_strobe_o;
    logic          m_rw_o;
    logic [AW-1:0] m_addr_o;
    logic [LS-1:0] m_wdata_o;
    logic          m_ready_i = 1'b0;
    logic [LS-1:0] m_data_i = '0;
    logic [31:0]   i_cnt_o;
    logic [31:0]   d_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    logic [LS-1:0] pat_a5;
    logic [LS-1:0] pat_wb;
    logic [LS-1:0] pat_x;
    logic [LS-1:0] pat_y;

    mem_arbiter #(.ADDR_WIDTH(AW), .LINE_SIZE(LS)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .i_strobe_i (i_strobe_i),
        .i_addr_i   (i_addr_i),
        .i_ready_o  (i_ready_o),
        .i_data_o   (i_data_o),
        .d_strobe_i (d_strobe_i),
        .d_rw_i     (d_rw_i),
        .d_addr_i   (d_addr_i),
        .d_wdata_i  (d_wdata_i),
        .d_ready_o  (d_ready_o),
        .d_data_o   (d_data_o),
        .m_strobe_o (m_strobe_o),
        .m_rw_o     (m_rw_o),
        .m_addr_o   (m_addr_o),
        .m_wdata_o  (m_wdata_o),
        .m_ready_i  (m_ready_i),
        .m_data_i   (m_data_i),
        .i_cnt_o    (i_cnt_o),
        .d_cnt_o    (d_cnt_o)
    );

    // Clock / watchdog
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, required summary before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [LS-1:0] obs, input logic [LS-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    initial begin
        pat_a5 = {32{8'hA5}};
        pat_wb = {4{64'h0123_4567_89AB_CDEF}};
        pat_x  = {8{32'h1111_2222}};
        pat_y  = {8{32'h3333_4444}};

        // ---------------- reset state ----------------
        #2;
        chk("rst_m_strobe", m_strobe_o, 0);
        chk("rst_m_addr",   m_addr_o,   0);
        chk("rst_m_wdata",  m_wdata_o,  0);
        chk("rst_m_rw",     m_rw_o,     0);
        chk("rst_i_ready",  i_ready_o,  0);
        chk("rst_d_ready",  d_ready_o,  0);
        chk("rst_i_cnt",    i_cnt_o,    0);
        chk("rst_d_cnt",    d_cnt_o,    0);
        cyc();
        rst_ni = 1'b1;
        cyc();                                   // cycle 1
        cyc();                                   // cycle 2: I strobe rises

        // ---------------- single I-cache read ----------------
        i_strobe_i = 1'b1;
        i_addr_i   = 32'h8000_0040;
        #1;
        chk("s1_c2_m_strobe", m_strobe_o, 0);
        cyc();                                   // cycle 3
        chk("s1_c3_m_strobe", m_strobe_o, 1);
        chk("s1_c3_m_addr",   m_addr_o,   32'h8000_0040);
        chk("s1_c3_m_rw",     m_rw_o,     0);
        chk("s1_c3_m_wdata",  m_wdata_o,  0);
        chk("s1_c3_i_ready",  i_ready_o,  0);
        cyc();                                   // cycle 4
        chk("s1_c4_m_strobe", m_strobe_o, 1);
        cyc();                                   // cycle 5
        chk("s1_c5_m_strobe", m_strobe_o, 1);
        chk("s1_c5_i_ready",  i_ready_o,  0);
        cyc();                                   // cycle 6: memory completes
        m_ready_i = 1'b1;
        m_data_i  = pat_a5;
        #1;
        chk("s1_c6_m_strobe", m_strobe_o, 1);
        chk("s1_c6_i_ready",  i_ready_o,  1);
        chk("s1_c6_i_data",   i_data_o,   pat_a5);
        chk("s1_c6_d_ready",  d_ready_o,  0);
        cyc();                                   // cycle 7: RECOVER, strobe stale
        m_ready_i = 1'b0;
        m_data_i  = '0;
        #1;
        chk("s1_c7_m_strobe", m_strobe_o, 0);
        chk("s1_c7_m_addr",   m_addr_o,   0);
        chk("s1_c7_i_ready",  i_ready_o,  0);
        chk("s1_c7_i_cnt",    i_cnt_o,    1);
        chk("s1_c7_d_cnt",    d_cnt_o,    0);
        i_strobe_i = 1'b0;
        cyc();                                   // cycle 8: IDLE
        chk("stale_c8_m_strobe", m_strobe_o, 0);
        cyc();                                   // cycle 9: spurious ready in IDLE
        chk("stale_c9_m_strobe", m_strobe_o, 0);
        m_ready_i = 1'b1;
        m_data_i  = pat_x;
        #1;
        chk("spur_i_ready", i_ready_o, 0);
        chk("spur_d_ready", d_ready_o, 0);
        cyc();
        m_ready_i = 1'b0;
        #1;
        chk("spur_m_strobe", m_strobe_o, 0);
        chk("spur_i_cnt",    i_cnt_o,    1);
        chk("spur_d_cnt",    d_cnt_o,    0);

        // ---------------- tie after reset ----------------
        #2;
        rst_ni = 1'b0;
        #2;
        rst_ni = 1'b1;
        cyc();                                   // t0: IDLE, both rise
        i_strobe_i = 1'b1;
        i_addr_i   = 32'h0000_1100;
        d_strobe_i = 1'b1;
        d_rw_i     = 1'b0;
        d_addr_i   = 32'h0000_2200;
        cyc();                                   // t1: I served first
        chk("tie1_m_addr",   m_addr_o,   32'h0000_1100);
        chk("tie1_m_strobe", m_strobe_o, 1);
        m_ready_i = 1'b1;
        m_data_i  = pat_x;
        #1;
        chk("tie1_i_ready", i_ready_o, 1);
        chk("tie1_d_ready", d_ready_o, 0);
        cyc();                                   // t2: RECOVER
        m_ready_i  = 1'b0;
        i_strobe_i = 1'b0;
        #1;
        chk("tie1_t2_m_strobe", m_strobe_o, 0);
        cyc();                                   // t3: IDLE
        chk("tie1_t3_m_strobe", m_strobe_o, 0);
        cyc();                                   // t4: D starts, 3 cycles after I ready
        chk("tie1_t4_m_strobe", m_strobe_o, 1);
        chk("tie1_t4_m_addr",   m_addr_o,   32'h0000_2200);
        m_ready_i = 1'b1;
        m_data_i  = pat_y;
        #1;
        chk("tie1_t4_d_ready", d_ready_o, 1);
        chk("tie1_t4_d_data",  d_data_o,  pat_y);
        chk("tie1_t4_i_ready", i_ready_o, 0);
        cyc();                                   // t5: RECOVER, re-raise I (D still high)
        m_ready_i  = 1'b0;
        i_strobe_i = 1'b1;
        #1;
        chk("tie1_t5_i_cnt", i_cnt_o, 1);
        chk("tie1_t5_d_cnt", d_cnt_o, 1);
        cyc();                                   // t6: IDLE tie, D served last -> I
        cyc();                                   // t7
        chk("tie2_m_addr", m_addr_o, 32'h0000_1100);
        m_ready_i = 1'b1;
        #1;
        chk("tie2_i_ready", i_ready_o, 1);
        cyc();                                   // t8: RECOVER, both stay high
        m_ready_i = 1'b0;
        cyc();                                   // t9: IDLE tie, I served last -> D
        cyc();                                   // t10
        chk("tie3_m_addr", m_addr_o, 32'h0000_2200);
        m_ready_i = 1'b1;
        #1;
        chk("tie3_d_ready", d_ready_o, 1);
        chk("tie3_i_ready", i_ready_o, 0);
        cyc();
        m_ready_i  = 1'b0;
        i_strobe_i = 1'b0;
        d_strobe_i = 1'b0;
        #1;
        chk("tie3_i_cnt", i_cnt_o, 2);
        chk("tie3_d_cnt", d_cnt_o, 2);
        cyc();                                   // IDLE

        // ---------------- D-cache write-back ----------------
        d_strobe_i = 1'b1;
        d_rw_i     = 1'b1;
        d_addr_i   = 32'h8000_1000;
        d_wdata_i  = pat_wb;
        cyc();
        chk("wb_m_rw",    m_rw_o,    1);
        chk("wb_m_addr",  m_addr_o,  32'h8000_1000);
        chk("wb_m_wdata", m_wdata_o, pat_wb);
        d_wdata_i = pat_x;                       // SERVE must keep latched values
        cyc();
        chk("wb_hold_wdata", m_wdata_o, pat_wb);
        m_ready_i = 1'b1;
        #1;
        chk("wb_d_ready", d_ready_o, 1);
        cyc();                                   // RECOVER; ready held high is ignored
        #1;
        chk("wb_rec_wdata",   m_wdata_o, 0);
        chk("wb_rec_rw",      m_rw_o,    0);
        chk("wb_rec_d_ready", d_ready_o, 0);
        chk("wb_rec_d_cnt",   d_cnt_o,   3);
        d_strobe_i = 1'b0;
        d_rw_i     = 1'b0;
        cyc();                                   // IDLE
        m_ready_i = 1'b0;
        #1;
        chk("wb_idle_d_cnt",    d_cnt_o,    3);
        chk("wb_idle_m_strobe", m_strobe_o, 0);

        // ---------------- reset mid-SERVE ----------------
        i_strobe_i = 1'b1;
        i_addr_i   = 32'h0000_3300;
        cyc();
        chk("rs_serve_m_strobe", m_strobe_o, 1);
        #2;
        rst_ni    = 1'b0;
        m_ready_i = 1'b1;
        #1;
        chk("rs_m_strobe", m_strobe_o, 0);
        chk("rs_m_addr",   m_addr_o,   0);
        chk("rs_i_cnt",    i_cnt_o,    0);
        chk("rs_d_cnt",    d_cnt_o,    0);
        chk("rs_i_ready",  i_ready_o,  0);
        cyc();
        m_ready_i  = 1'b0;
        rst_ni     = 1'b1;
        d_strobe_i = 1'b1;
        d_addr_i   = 32'h0000_4400;
        cyc();                                   // tie after release -> I
        chk("rs_tie_m_addr", m_addr_o, 32'h0000_3300);
        m_ready_i = 1'b1;
        #1;
        chk("rs_tie_i_ready", i_ready_o, 1);
        cyc();                                   // RECOVER
        m_ready_i  = 1'b0;
        i_strobe_i = 1'b0;
        cyc();                                   // IDLE -> D
        cyc();
        chk("rs_d_m_addr", m_addr_o, 32'h0000_4400);
        m_ready_i = 1'b1;
        cyc();
        m_ready_i  = 1'b0;
        d_strobe_i = 1'b0;
        #1;
        chk("rs_end_i_cnt", i_cnt_o, 1);
        chk("rs_end_d_cnt", d_cnt_o, 1);
        cyc();                                   // IDLE

        // ---------------- counter wrap ----------------
        force dut.i_cnt_q = 32'hFFFF_FFFF;
        cyc();
        release dut.i_cnt_q;
        #1;
        chk("wrap_pre_i_cnt", i_cnt_o, 32'hFFFF_FFFF);
        i_strobe_i = 1'b1;
        i_addr_i   = 32'h0000_5500;
        cyc();
        m_ready_i = 1'b1;
        #1;
        chk("wrap_i_ready", i_ready_o, 1);
        cyc();
        m_ready_i  = 1'b0;
        i_strobe_i = 1'b0;
        #1;
        chk("wrap_i_cnt", i_cnt_o, 0);
        chk("wrap_d_cnt", d_cnt_o, 1);
        cyc();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
